// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART receive definitions.
// Baud-select codes, FSM states, tick points and divisor helper.
package uart_rx_pkg;

    localparam int DIV_W = 16;

    localparam logic [2:0] BAUD_2400   = 3'b000;
    localparam logic [2:0] BAUD_4800   = 3'b001;
    localparam logic [2:0] BAUD_38400  = 3'b010;
    localparam logic [2:0] BAUD_57600  = 3'b011;
    localparam logic [2:0] BAUD_9600   = 3'b100;
    localparam logic [2:0] BAUD_19200  = 3'b101;
    localparam logic [2:0] BAUD_115200 = 3'b110;
    localparam logic [2:0] BAUD_115K_B = 3'b111;

    // Sample points inside one 16-tick bit cell.
    localparam logic [3:0] TICK_S0  = 4'd7;
    localparam logic [3:0] TICK_S1  = 4'd8;
    localparam logic [3:0] TICK_MID = 4'd9;
    localparam logic [3:0] TICK_END = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // round(clk_freq / (baud * 16)), never below 1
    function automatic logic [DIV_W-1:0] baud_div(
        input int clk_freq,
        input int baud
    );
        longint q;
        q = (longint'(clk_freq) + longint'(baud) * 8)
            / (longint'(baud) * 16);
        if (q < 1) q = 1;
        return q[DIV_W-1:0];
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte delivery bus of the UART receiver.
// data/valid/ack handshake plus busy and 1-cycle status pulses.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ack;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output data, valid, busy,
        output frame_err, overrun, parity_err,
        input  ack
    );

    modport slave (
        input  data, valid, busy,
        input  frame_err, overrun, parity_err,
        output ack
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divisor counter emitting the 16x oversampling tick.
// Ports: clk, rst_n, restart (sync re-phase), div, tick.
module uart_baud_gen
    import uart_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt >= div - ONE);
    assign tick = wrap && !restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling 8N1 receiver with one-entry holding reg.
// Ports: clk, rst_n, baud_sel, rx, bus (uart_rx_if.master).
// Define RX_PARITY_EN for 8E1/8O1 frames (PARITY_ODD picks sense).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_sel,
    input  logic       rx,
    uart_rx_if.master  bus
);

    localparam logic [DIV_W-1:0] D_2400   = baud_div(CLK_FREQ, 2400);
    localparam logic [DIV_W-1:0] D_4800   = baud_div(CLK_FREQ, 4800);
    localparam logic [DIV_W-1:0] D_9600   = baud_div(CLK_FREQ, 9600);
    localparam logic [DIV_W-1:0] D_19200  = baud_div(CLK_FREQ, 19200);
    localparam logic [DIV_W-1:0] D_38400  = baud_div(CLK_FREQ, 38400);
    localparam logic [DIV_W-1:0] D_57600  = baud_div(CLK_FREQ, 57600);
    localparam logic [DIV_W-1:0] D_115200 = baud_div(CLK_FREQ, 115200);

    logic             rx_q1, rx_s, rx_prev;
    rx_state_t        state, state_d;
    logic [DIV_W-1:0] div_sel, div_q;
    logic             tick;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [1:0]       samp;
    logic             maj, start_det, at_mid, at_end;
    logic             load, ferr;
    logic [7:0]       data_q;
    logic             valid_q, ferr_q, ovr_q;
`ifdef RX_PARITY_EN
    logic             par_bad, perr, perr_q;
`endif

    always_comb begin
        div_sel = D_9600;
        unique case (baud_sel)
            BAUD_2400:   div_sel = D_2400;
            BAUD_4800:   div_sel = D_4800;
            BAUD_38400:  div_sel = D_38400;
            BAUD_57600:  div_sel = D_57600;
            BAUD_9600:   div_sel = D_9600;
            BAUD_19200:  div_sel = D_19200;
            BAUD_115200: div_sel = D_115200;
            BAUD_115K_B: div_sel = D_115200;
        endcase
    end

    // Sync flops idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_q1   <= rx;
            rx_s    <= rx_q1;
            rx_prev <= rx_s;
        end
    end

    assign start_det = (state == ST_IDLE) && rx_prev && !rx_s;
    assign at_mid    = tick && (tick_cnt == TICK_MID);
    assign at_end    = tick && (tick_cnt == TICK_END);
    // 2-of-3 vote over ticks 7, 8 and the live tick-9 sample
    assign maj = (samp[0] & samp[1]) | (samp[0] & rx_s)
               | (samp[1] & rx_s);

    uart_baud_gen u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (start_det),
        .div     (div_q),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        ferr    = 1'b0;
`ifdef RX_PARITY_EN
        perr    = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (start_det) state_d = ST_START;
            end
            ST_START: begin
                if (at_mid && maj) state_d = ST_IDLE;
                else if (at_end)   state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_end && bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef RX_PARITY_EN
            ST_PARITY: begin
                if (at_end) state_d = ST_STOP;
            end
`endif
            // Decide at mid stop bit so a following start is not missed.
            ST_STOP: begin
                if (at_mid) begin
                    if (!maj) begin
                        ferr    = 1'b1;
                        state_d = ST_BREAK;
`ifdef RX_PARITY_EN
                    end else if (par_bad) begin
                        perr    = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        load    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            samp     <= '0;
        end else if (start_det) begin
            div_q    <= div_sel;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (tick && state != ST_IDLE) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == TICK_S0) samp[0] <= rx_s;
            if (tick_cnt == TICK_S1) samp[1] <= rx_s;
            if (state == ST_DATA && tick_cnt == TICK_MID)
                shift <= {maj, shift[7:1]};
            if (state == ST_DATA && tick_cnt == TICK_END)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_bad <= 1'b0;
        else if (start_det)
            par_bad <= 1'b0;
        else if (at_mid && state == ST_PARITY)
            par_bad <= maj ^ (^shift) ^ PARITY_ODD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr;
    end

    assign bus.parity_err = perr_q;
`else
    logic unused_par;
    assign unused_par     = PARITY_ODD;
    assign bus.parity_err = 1'b0;
`endif

    // A full register refuses a new byte unless it is acked this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= ferr;
            ovr_q  <= load && valid_q && !bus.ack;
            if (load && (!valid_q || bus.ack)) begin
                data_q  <= shift;
                valid_q <= 1'b1;
            end else if (bus.ack && valid_q) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx, bit-banged serial frames.
// Small CLK_FREQ keeps divisors short (9600 baud -> 12 clocks/tick).
module tb_uart_rx;

    localparam int CLK_FREQ = 1_843_200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [2:0] baud_sel;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_sel (baud_sel),
        .rx       (rx),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;

    logic [7:0] exp_q[$];

    // Pulse counters, sampled 2ns after the rising edge.
    always begin
        @(posedge clk);
        #2;
        if (bus.frame_err === 1'b1)  fe_cnt++;
        if (bus.overrun === 1'b1)    ov_cnt++;
        if (bus.parity_err === 1'b1) pe_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1);
    end

    function automatic int div_of(input logic [2:0] s);
        case (s)
            3'b000:  return 48;
            3'b001:  return 24;
            3'b010:  return 3;
            3'b011:  return 2;
            3'b100:  return 12;
            3'b101:  return 6;
            default: return 1;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input int div,
                             input logic stop);
        int bitc;
        bitc = 16 * div;
        rx = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bitc) @(negedge clk);
        end
`ifdef RX_PARITY_EN
        rx = ^b;
        repeat (bitc) @(negedge clk);
`endif
        rx = stop;
        repeat (bitc) @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: valid=%b after %0d cycles, required 1",
                     bus.valid, limit);
        end
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        bus.ack = 1'b0;
        baud_sel = 3'b100;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.data, bus.valid, bus.busy, bus.frame_err,
             bus.overrun, bus.parity_err} !== 13'h0) begin
            errors++;
            $display("FAIL reset_hold: data=%h valid=%b busy=%b, required 0",
                     bus.data, bus.valid, bus.busy);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: valid=%b busy=%b, required 0 0",
                     bus.valid, bus.busy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int fe0;
        logic [7:0] e;
        exp_q.delete();
        fe0 = fe_cnt;
        baud_sel = 3'b100;
        exp_q.push_back(8'h55);
        send_byte(8'h55, div_of(3'b100), 1'b1);
        wait_valid(800, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.data !== e) begin
                errors++;
                $display("FAIL basic_data: got %h, required %h", bus.data, e);
            end
            pulse_ack();
            checks++;
            if (bus.valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_ack: valid=%b, required 0", bus.valid);
            end
        end
        checks++;
        if (fe_cnt != fe0) begin
            errors++;
            $display("FAIL basic_ferr: pulses=%0d, required 0", fe_cnt - fe0);
        end
    endtask

    task automatic test_back_to_back();
        int ov0, fe0;
        exp_q.delete();
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        baud_sel = 3'b010;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hEF);
        fork
            begin
                send_byte(8'hAA, div_of(3'b010), 1'b1);
                send_byte(8'hEF, div_of(3'b011), 1'b1);
            end
            begin
                // Mid-frame change must not disturb the running frame.
                repeat (60) @(negedge clk);
                baud_sel = 3'b000;
                repeat (300) @(negedge clk);
                baud_sel = 3'b011;
            end
            begin
                bit ok;
                logic [7:0] e;
                for (int k = 0; k < 2; k++) begin
                    wait_valid(1500, ok);
                    if (ok) begin
                        e = exp_q.pop_front();
                        checks++;
                        if (bus.data !== e) begin
                            errors++;
                            $display("FAIL b2b_data%0d: got %h, required %h",
                                     k, bus.data, e);
                        end
                        pulse_ack();
                        checks++;
                        if (bus.valid !== 1'b0) begin
                            errors++;
                            $display("FAIL b2b_ack%0d: valid=%b, required 0",
                                     k, bus.valid);
                        end
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        checks++;
        if (ov_cnt != ov0 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL b2b_flags: ovr=%0d ferr=%0d, required 0 0",
                     ov_cnt - ov0, fe_cnt - fe0);
        end
    endtask

    task automatic test_glitch();
        int ov0, fe0, pe0;
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        baud_sel = 3'b100;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_hi: busy=%b, required 1", bus.busy);
        end
        repeat (300) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: busy=%b valid=%b, required 0 0",
                     bus.busy, bus.valid);
        end
        checks++;
        if (ov_cnt != ov0 || fe_cnt != fe0 || pe_cnt != pe0) begin
            errors++;
            $display("FAIL glitch_flags: ovr=%0d ferr=%0d perr=%0d, required 0",
                     ov_cnt - ov0, fe_cnt - fe0, pe_cnt - pe0);
        end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        baud_sel = 3'b100;
        send_byte(8'h3C, div_of(3'b100), 1'b0);
        repeat (4 * 16 * div_of(3'b100)) @(negedge clk);
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL ferr_pulse: pulses=%0d, required 1", fe_cnt - fe0);
        end
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ferr_hold: valid=%b busy=%b, required 0 1",
                     bus.valid, bus.busy);
        end
        rx = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_release: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_overrun();
        int ov0;
        logic [7:0] e;
        exp_q.delete();
        ov0 = ov_cnt;
        baud_sel = 3'b110;
        exp_q.push_back(8'h11);
        send_byte(8'h11, div_of(3'b110), 1'b1);
        send_byte(8'h22, div_of(3'b110), 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL ovr_pulse: pulses=%0d, required 1", ov_cnt - ov0);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.valid !== 1'b1 || bus.data !== e) begin
            errors++;
            $display("FAIL ovr_keep: valid=%b data=%h, required 1 %h",
                     bus.valid, bus.data, e);
        end
        pulse_ack();
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_ack: valid=%b, required 0", bus.valid);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int fe0, ov0, bitc;
        logic [7:0] b, e;
        exp_q.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        baud_sel = 3'b100;
        bitc = 16 * div_of(3'b100);
        b = 8'h5A;
        rx = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (bitc) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.data, bus.valid, bus.busy, bus.frame_err,
             bus.overrun, bus.parity_err} !== 13'h0) begin
            errors++;
            $display("FAIL rst_mid_out: data=%h valid=%b busy=%b, required 0",
                     bus.data, bus.valid, bus.busy);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, div_of(3'b100), 1'b1);
        wait_valid(800, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.data !== e) begin
                errors++;
                $display("FAIL rst_mid_data: got %h, required %h", bus.data, e);
            end
            pulse_ack();
        end
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL rst_mid_flags: ferr=%0d ovr=%0d, required 0 0",
                     fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_parity_quiet();
        checks++;
        if (pe_cnt != 0) begin
            errors++;
            $display("FAIL parity_quiet: pulses=%0d, required 0", pe_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_parity_quiet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
